// File: rtl/reg_bank_loader.sv
// Four-register bank feeding the downstream 4:1 select mux.
// Registers are loaded either by a direct single-word write (only while the
// loader is idle) or by a 4-word valid/ready burst that fills r0..r3 in order.
module reg_bank_loader #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         start,
  input  logic         abort,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic         wr_err,
  output logic [N-1:0] r0,
  output logic [N-1:0] r1,
  output logic [N-1:0] r2,
  output logic [N-1:0] r3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic       done_reg, wr_err_reg;
  logic       accept;
  logic       direct_wr;

  // Direct writes land only while idle; anything else is rejected.
  assign direct_wr = (state_reg == IDLE) && wr_en;

  // Next-state, load index and decoded stream handshake.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = 2'd0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Abort wins over a simultaneous valid word, even though ready reads 1.
        if (abort) begin
          state_next = IDLE;
        end else if (in_valid) begin
          accept   = 1'b1;
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and load index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Registered status pulses: done marks the DONE cycle, wr_err flags a rejected write.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg   <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      done_reg   <= accept && (idx_reg == 2'd3);
      wr_err_reg <= wr_en && (state_reg != IDLE);
    end
  end

  // One flop bank per register; direct and burst writes are mutually exclusive by state.
  for (genvar gi = 0; gi < 4; gi++) begin : g_reg
    logic [N-1:0] q_reg;
    logic         direct_hit;
    logic         burst_hit;

    assign direct_hit = direct_wr && (wr_addr == 2'(gi));
    assign burst_hit  = accept && (idx_reg == 2'(gi));

    // Register update: reset, direct write, or burst word capture.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg <= '0;
      end else if (direct_hit) begin
        q_reg <= wr_data;
      end else if (burst_hit) begin
        q_reg <= in_data;
      end
    end
  end

  assign r0     = g_reg[0].q_reg;
  assign r1     = g_reg[1].q_reg;
  assign r2     = g_reg[2].q_reg;
  assign r3     = g_reg[3].q_reg;
  assign done   = done_reg;
  assign wr_err = wr_err_reg;

endmodule

// File: tb/tb_reg_bank_loader.sv
// Self-checking bench for reg_bank_loader: directed steps from the test plan
// followed by a randomized phase, all checked against a behavioural model.
module tb_reg_bank_loader;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         start;
  logic         abort;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic         wr_err;
  logic [N-1:0] r0, r1, r2, r3;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: register contents, burst progress as a word count.
  logic [N-1:0] m_r [4];
  bit           m_loading;
  int           m_count;
  bit           m_done;
  bit           m_err;

  always #5 clk = ~clk;

  reg_bank_loader #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .wr_err   (wr_err),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("assertion %s", tag);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit was_idle;
    was_idle = !m_loading && !m_done;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_r[i] = '0;
      m_loading = 0; m_count = 0; m_done = 0; m_err = 0;
    end else begin
      m_err = wr_en && !was_idle;
      if (was_idle) begin
        if (wr_en) m_r[wr_addr] = wr_data;
        if (start) begin
          m_loading = 1; m_count = 0;
        end
      end else if (m_loading) begin
        if (abort) begin
          m_loading = 0;
        end else if (in_valid) begin
          m_r[m_count] = in_data;
          m_count++;
          if (m_count == 4) begin
            m_loading = 0; m_done = 1;
          end
        end
      end else begin
        m_done = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("r0", 32'(r0), 32'(m_r[0]));
    chk("r1", 32'(r1), 32'(m_r[1]));
    chk("r2", 32'(r2), 32'(m_r[2]));
    chk("r3", 32'(r3), 32'(m_r[3]));
    chk("in_ready", 32'(in_ready), 32'(m_loading));
    chk("busy", 32'(busy), 32'(m_loading || m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("wr_err", 32'(wr_err), 32'(m_err));
  endtask

  // One clock: model update at the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string what);
    @(posedge clk);
    model_step();
    #1;
    check_all();
    $display("[TB] %s rst=%0b wr=%0b@%0d:%0h st=%0b ab=%0b v=%0b d=%0h -> r=%0h%0h%0h%0h busy=%0b done=%0b err=%0b",
             what, rst, wr_en, wr_addr, wr_data, start, abort, in_valid, in_data,
             r3, r2, r1, r0, busy, done, wr_err);
  endtask

  task automatic push_word(input logic [N-1:0] w);
    in_valid = 1'b1; in_data = w;
    cycle("word");
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_loading = 0; m_count = 0; m_done = 0; m_err = 0;
    idle_inputs();
    #2;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1; wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = N'($urandom);
      start = 1'($urandom); abort = 1'($urandom); in_valid = 1'($urandom); in_data = N'($urandom);
      cycle("reset");
    end
    idle_inputs();
    chk("reset_r0", 32'(r0), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Direct writes in IDLE.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'hA;
    cycle("direct");
    chk("direct_r2", 32'(r2), 32'hA);
    wr_addr = 2'd0; wr_data = 4'h5;
    cycle("direct");
    idle_inputs();
    chk("direct_r0", 32'(r0), 32'h5);
    chk("direct_busy", 32'(busy), 32'h0);

    // Burst with a word offered alongside start (must be ignored) and a 2-cycle gap.
    start = 1'b1; in_valid = 1'b1; in_data = 4'hE;
    cycle("start");
    idle_inputs();
    chk("start_no_capture_r0", 32'(r0), 32'h5);
    chk("load_in_ready", 32'(in_ready), 32'h1);
    push_word(4'h1);
    push_word(4'h2);
    cycle("stall");
    cycle("stall");
    push_word(4'h3);
    chk("stall_no_done", 32'(done), 32'h0);
    push_word(4'h4);
    chk("burst_done", 32'(done), 32'h1);
    chk("burst_r3", 32'(r3), 32'h4);
    chk("done_no_ready", 32'(in_ready), 32'h0);
    cycle("after_done");
    chk("done_cleared", 32'(done), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("burst_r1", 32'(r1), 32'h2);

    // Direct write rejected during LOAD while the burst proceeds.
    start = 1'b1;
    cycle("start");
    idle_inputs();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'hF;
    push_word(4'h6);
    wr_en = 1'b0;
    chk("reject_err", 32'(wr_err), 32'h1);
    chk("reject_r1", 32'(r1), 32'h2);
    push_word(4'h7);
    chk("reject_err_once", 32'(wr_err), 32'h0);
    chk("reject_r1_burst", 32'(r1), 32'h7);
    push_word(4'h8);
    push_word(4'h9);
    chk("reject_burst_done", 32'(done), 32'h1);
    cycle("after_done");

    // Abort with a word pending.
    start = 1'b1;
    cycle("start");
    idle_inputs();
    push_word(4'h7);
    push_word(4'h8);
    abort = 1'b1; in_valid = 1'b1; in_data = 4'h9;
    cycle("abort");
    idle_inputs();
    chk("abort_r0", 32'(r0), 32'h7);
    chk("abort_r1", 32'(r1), 32'h8);
    chk("abort_r2", 32'(r2), 32'h8);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_no_done", 32'(done), 32'h0);
    cycle("idle");

    // Reset mid-burst, then a clean burst.
    start = 1'b1;
    cycle("start");
    idle_inputs();
    push_word(4'hC);
    push_word(4'hD);
    rst = 1'b1;
    cycle("reset_mid");
    idle_inputs();
    chk("midrst_r0", 32'(r0), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    start = 1'b1;
    cycle("start");
    idle_inputs();
    push_word(4'h3);
    push_word(4'hB);
    push_word(4'h1);
    push_word(4'h6);
    chk("reload_done", 32'(done), 32'h1);
    chk("reload_r0", 32'(r0), 32'h3);
    chk("reload_r3", 32'(r3), 32'h6);
    cycle("after_done");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 2'($urandom);
      wr_data  = N'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 11) == 0);
      in_valid = 1'($urandom);
      in_data  = N'($urandom);
      cycle("rand");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
